// File: rtl/window_stream_pkg.sv
// Shared defaults and helpers for the window_stream pixel-window generator.
// The frame geometry and pixel width come from global macros so a whole
// imaging pipeline can be retargeted from one place; the fallbacks below
// apply when nothing else defines them.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
`ifndef FRAME_WIDTH
`define FRAME_WIDTH 8
`endif
`ifndef FRAME_HEIGHT
`define FRAME_HEIGHT 6
`endif

package window_stream_pkg;

    localparam int DEF_WORD_SIZE    = `WORD_SIZE;
    localparam int DEF_FRAME_WIDTH  = `FRAME_WIDTH;
    localparam int DEF_FRAME_HEIGHT = `FRAME_HEIGHT;
    localparam int DEF_WIN_W        = 3;
    localparam int DEF_WIN_H        = 3;
    localparam int DEF_ADDR_WIDTH   = 11;

    // Index width needed to address 'depth' RAM words (at least one bit).
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/window_stream_line_buffer.sv
// Circular delay line: the word read out is the one written DEPTH accepted
// cycles earlier. Read is combinational from the current pointer and the
// write lands at the same address, so each slot is read just before it is
// overwritten. RAM contents are deliberately not reset.
module line_buffer
    import window_stream_pkg::*;
#(
    parameter int WORD_SIZE  = DEF_WORD_SIZE,
    parameter int DEPTH      = DEF_FRAME_WIDTH - DEF_WIN_W,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en_i,
    input  logic [WORD_SIZE-1:0] din_i,
    output logic [WORD_SIZE-1:0] dout_o
);

    localparam int IW = idx_width(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);

    logic [WORD_SIZE-1:0]  mem_q [2**IW];
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_d;

    assign dout_o = mem_q[ptr_q[IW-1:0]];
    assign ptr_d  = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;

    // Store the incoming word in the slot just read out.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[ptr_q[IW-1:0]] <= din_i;
        end
    end

    // Advance the single read/write pointer on every accepted word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (en_i) begin
            ptr_q <= ptr_d;
        end
    end

    // The pointer never exceeds DEPTH-1, so its high bits carry no address.
    if (ADDR_WIDTH > IW) begin : g_ptr_hi
        logic unused_ptr_hi;
        assign unused_ptr_hi = ^ptr_q[ADDR_WIDTH-1:IW];
    end

endmodule

// File: rtl/window_stream.sv
// Streaming WIN_W x WIN_H pixel-window generator with frame tracking.
// p[0][0] holds the newest pixel; p[i][j] is the pixel i rows up and j
// columns left of it in raster order. col/row describe p[0][0]; dout_valid
// flags windows lying wholly inside the current frame, eof marks the last
// pixel of a frame.
module window_stream
    import window_stream_pkg::*;
#(
    parameter int WORD_SIZE    = DEF_WORD_SIZE,
    parameter int WIN_W        = DEF_WIN_W,
    parameter int WIN_H        = DEF_WIN_H,
    parameter int FRAME_WIDTH  = DEF_FRAME_WIDTH,
    parameter int FRAME_HEIGHT = DEF_FRAME_HEIGHT,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               en,
    input  logic                               sof,
    input  logic [WORD_SIZE-1:0]               din,
    output logic [WIN_W*WIN_H*WORD_SIZE-1:0]   dout,
    output logic                               dout_valid,
    output logic [ADDR_WIDTH-1:0]              col,
    output logic [ADDR_WIDTH-1:0]              row,
    output logic                               eof
);

    localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_LAST = ADDR_WIDTH'(FRAME_HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] COL_MIN  = ADDR_WIDTH'(WIN_W - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_MIN  = ADDR_WIDTH'(WIN_H - 1);

    logic [WORD_SIZE-1:0]  tap_q  [WIN_H][WIN_W];
    logic [WORD_SIZE-1:0]  row_in [WIN_H];
    logic [ADDR_WIDTH-1:0] col_q, col_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d;
    logic                  started_q;
    logic                  valid_q, valid_d;
    logic                  eof_q, eof_d;

    // Row 0 is fed by the input pixel, row i by the line buffer that delays
    // the pixel leaving the right end of row i-1.
    assign row_in[0] = din;

    for (genvar i = 1; i < WIN_H; i++) begin : g_lb
        line_buffer #(
            .WORD_SIZE  (WORD_SIZE),
            .DEPTH      (FRAME_WIDTH - WIN_W),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_line_buffer (
            .clk     (clk),
            .reset_n (reset_n),
            .en_i    (en),
            .din_i   (tap_q[i-1][WIN_W-1]),
            .dout_o  (row_in[i])
        );
    end

    for (genvar i = 0; i < WIN_H; i++) begin : g_dout_row
        for (genvar j = 0; j < WIN_W; j++) begin : g_dout_col
            assign dout[(i*WIN_W+j+1)*WORD_SIZE-1 -: WORD_SIZE] = tap_q[i][j];
        end
    end

    // Position of the pixel about to land in p[0][0]. The first pixel after
    // reset and every sof-qualified pixel restart the frame at (0,0).
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (sof || !started_q) begin
            col_d = '0;
            row_d = '0;
        end else if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
            col_d = col_q + 1'b1;
        end
        valid_d = (row_d >= ROW_MIN) && (col_d >= COL_MIN);
        eof_d   = !sof && (col_d == COL_LAST) && (row_d == ROW_LAST);
    end

    // Shift every window row one pixel on each accepted cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIN_H; i++) begin
                for (int j = 0; j < WIN_W; j++) begin
                    tap_q[i][j] <= '0;
                end
            end
        end else if (en) begin
            for (int i = 0; i < WIN_H; i++) begin
                tap_q[i][0] <= row_in[i];
                for (int j = 1; j < WIN_W; j++) begin
                    tap_q[i][j] <= tap_q[i][j-1];
                end
            end
        end
    end

    // Track frame position and register the per-pixel status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q     <= '0;
            row_q     <= '0;
            started_q <= 1'b0;
            valid_q   <= 1'b0;
            eof_q     <= 1'b0;
        end else if (en) begin
            col_q     <= col_d;
            row_q     <= row_d;
            started_q <= 1'b1;
            valid_q   <= valid_d;
            eof_q     <= eof_d;
        end else begin
            valid_q   <= 1'b0;
            eof_q     <= 1'b0;
        end
    end

    assign col        = col_q;
    assign row        = row_q;
    assign dout_valid = valid_q;
    assign eof        = eof_q;

endmodule

// File: tb/tb_window_stream.sv
// Self-checking bench for window_stream. A reference model keeps every
// accepted pixel since reset and derives window contents, position and
// status pulses from raster arithmetic on the stream index.
module tb_window_stream;

    localparam int WS       = 8;
    localparam int WW       = 3;
    localparam int WH       = 3;
    localparam int FW       = 8;
    localparam int FH       = 6;
    localparam int AW       = 11;
    localparam int WIN_BITS = WW * WH * WS;

    // ---------------- clock / reset ----------------
    logic                clk     = 1'b0;
    logic                reset_n = 1'b0;
    logic                en      = 1'b0;
    logic                sof     = 1'b0;
    logic [WS-1:0]       din     = '0;
    logic [WIN_BITS-1:0] dout;
    logic                dout_valid;
    logic [AW-1:0]       col;
    logic [AW-1:0]       row;
    logic                eof;

    always #5 clk = ~clk;

    window_stream #(
        .WORD_SIZE    (WS),
        .WIN_W        (WW),
        .WIN_H        (WH),
        .FRAME_WIDTH  (FW),
        .FRAME_HEIGHT (FH),
        .ADDR_WIDTH   (AW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .sof        (sof),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .col        (col),
        .row        (row),
        .eof        (eof)
    );

    // ---------------- model / scoreboard state ----------------
    int                  checks   = 0;
    int                  failures = 0;
    logic [WS-1:0]       hist[$];
    logic [WIN_BITS-1:0] exp_q[$];
    int                  frame_start   = 0;
    int                  exp_col       = 0;
    int                  exp_row       = 0;
    int                  valid_cnt     = 0;
    int                  eof_cnt       = 0;
    int                  mark_n        = 0;
    int                  first_valid_n = -1;

    task automatic check(input string tag, input logic [WIN_BITS-1:0] got,
                         input logic [WIN_BITS-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Window whose newest pixel is stream index n.
    function automatic logic [WIN_BITS-1:0] window_at(input int n);
        logic [WIN_BITS-1:0] w;
        w = '0;
        for (int i = 0; i < WH; i++) begin
            for (int j = 0; j < WW; j++) begin
                w[(i*WW+j+1)*WS-1 -: WS] = hist[n - i*FW - j];
            end
        end
        return w;
    endfunction

    function automatic logic [WS-1:0] tap(input int i, input int j);
        return dout[(i*WW+j+1)*WS-1 -: WS];
    endfunction

    // ---------------- driver + per-cycle comparison ----------------
    task automatic step(input logic e, input logic s, input logic [WS-1:0] d);
        int   n;
        int   pos;
        logic ev;
        logic ee;
        @(negedge clk);
        en  = e;
        sof = s;
        din = d;
        @(posedge clk);
        #1;
        ev = 1'b0;
        ee = 1'b0;
        if (e) begin
            hist.push_back(d);
            n = hist.size() - 1;
            if (s || n == 0) frame_start = n;
            pos     = (n - frame_start) % (FW * FH);
            exp_col = pos % FW;
            exp_row = pos / FW;
            ev = (exp_row >= WH - 1) && (exp_col >= WW - 1);
            ee = (exp_col == FW - 1) && (exp_row == FH - 1);
            if (ev) begin
                exp_q.push_back(window_at(n));
                valid_cnt++;
                if (first_valid_n < 0) first_valid_n = n - mark_n;
            end
            if (ee) eof_cnt++;
        end
        check("col", WIN_BITS'(col), WIN_BITS'(exp_col));
        check("row", WIN_BITS'(row), WIN_BITS'(exp_row));
        check("dout_valid", WIN_BITS'(dout_valid), WIN_BITS'(ev));
        check("eof", WIN_BITS'(eof), WIN_BITS'(ee));
        if (hist.size() > 0)
            check("p00", WIN_BITS'(tap(0, 0)), WIN_BITS'(hist[hist.size()-1]));
        if (dout_valid) begin
            if (exp_q.size() == 0) check("sb_unexpected", 1, 0);
            else check("window", dout, exp_q.pop_front());
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int accepted;
        int guard;
        logic e;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", dout, '0);
        check("rst_valid", WIN_BITS'(dout_valid), 0);
        check("rst_eof", WIN_BITS'(eof), 0);
        check("rst_col", WIN_BITS'(col), 0);
        check("rst_row", WIN_BITS'(row), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Frame 1: continuous stream, din = raster index
        valid_cnt = 0; eof_cnt = 0; first_valid_n = -1; mark_n = 0;
        for (int k = 0; k < FW * FH; k++) begin
            step(1'b1, k == 0, WS'(k));
            if (k == 18) begin
                check("f1_p00", WIN_BITS'(tap(0, 0)), 18);
                check("f1_p02", WIN_BITS'(tap(0, 2)), 16);
                check("f1_p11", WIN_BITS'(tap(1, 1)), 9);
                check("f1_p22", WIN_BITS'(tap(2, 2)), 0);
            end
        end
        check("f1_valid_cnt", WIN_BITS'(valid_cnt), 24);
        check("f1_eof_cnt", WIN_BITS'(eof_cnt), 1);
        check("f1_first_valid", WIN_BITS'(first_valid_n), 18);

        // Frame 2: back-to-back without sof, random en gaps
        valid_cnt = 0; eof_cnt = 0; accepted = 0; guard = 0;
        while (accepted < FW * FH && guard < 1000) begin
            e = ($urandom_range(0, 2) != 0);
            step(e, 1'b0, WS'($urandom));
            if (e) accepted++;
            guard++;
        end
        check("f2_accepted", WIN_BITS'(accepted), FW * FH);
        check("f2_valid_cnt", WIN_BITS'(valid_cnt), 24);
        check("f2_eof_cnt", WIN_BITS'(eof_cnt), 1);

        // sof at pixel 20 aborts the frame
        step(1'b1, 1'b1, WS'($urandom));
        for (int k = 1; k < 20; k++) step(1'b1, 1'b0, WS'($urandom));
        step(1'b1, 1'b1, WS'($urandom));
        check("midsof_col", WIN_BITS'(col), 0);
        check("midsof_row", WIN_BITS'(row), 0);
        mark_n = hist.size() - 1; first_valid_n = -1;
        for (int k = 0; k < 25; k++) step(1'b1, 1'b0, WS'($urandom));
        check("midsof_first_valid", WIN_BITS'(first_valid_n), 18);

        // sof without en is ignored
        step(1'b1, 1'b1, WS'($urandom));
        for (int k = 1; k <= 10; k++) step(1'b1, 1'b0, WS'($urandom));
        step(1'b0, 1'b1, WS'($urandom));
        step(1'b1, 1'b0, WS'($urandom));
        check("idle_sof_col", WIN_BITS'(col), 3);
        check("idle_sof_row", WIN_BITS'(row), 1);

        // Asynchronous reset mid-row, between edges
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, WS'($urandom));
        @(negedge clk);
        en = 1'b0;
        sof = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("arst_dout", dout, '0);
        check("arst_valid", WIN_BITS'(dout_valid), 0);
        check("arst_eof", WIN_BITS'(eof), 0);
        check("arst_col", WIN_BITS'(col), 0);
        check("arst_row", WIN_BITS'(row), 0);
        check("arst_sb_empty", WIN_BITS'(exp_q.size()), 0);
        hist.delete();
        exp_q.delete();
        frame_start = 0;
        #1 reset_n = 1'b1;
        mark_n = 0; first_valid_n = -1;
        step(1'b1, 1'b0, WS'($urandom));
        check("arst_first_col", WIN_BITS'(col), 0);
        check("arst_first_row", WIN_BITS'(row), 0);
        for (int k = 1; k < 25; k++) step(1'b1, 1'b0, WS'($urandom));
        check("arst_first_valid", WIN_BITS'(first_valid_n), 18);

        // Final report
        step(1'b0, 1'b0, '0);
        check("sb_leftover", WIN_BITS'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/window_stream.md
Name: window_stream

Overview:
Streaming WIN_W x WIN_H pixel-window generator for image kernel stages (sobel, blur, threshold). It accepts one raster-order pixel per enabled cycle and keeps WIN_H-1 line buffers. Unlike the fixed window generator, it tracks frame position, resynchronises on start-of-frame, and flags windows that lie wholly inside the frame. It also reports the newest pixel's coordinates and an end-of-frame pulse, so downstream kernels need no counters of their own.

Parameters:
WORD_SIZE, `WORD_SIZE, bits per pixel
WIN_W, 3, window width in pixels (>=1, < FRAME_WIDTH)
WIN_H, 3, window height in rows (>=1)
FRAME_WIDTH, `FRAME_WIDTH, pixels per row
FRAME_HEIGHT, `FRAME_HEIGHT, rows per frame
ADDR_WIDTH, 11, line-buffer pointer width; 2**ADDR_WIDTH >= FRAME_WIDTH-WIN_W

Ports:
clk  in  1  clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
en  in  1  pixel accept strobe; din is sampled when high
sof  in  1  start of frame; qualified by en; marks din as pixel (0,0)
din  in  WORD_SIZE  pixel in
dout  out  WIN_W*WIN_H*WORD_SIZE  window; tap p[i][j] at bits [(i*WIN_W+j+1)*WORD_SIZE-1 -: WORD_SIZE]
dout_valid  out  1  one-cycle pulse: dout is a complete in-frame window
col  out  ADDR_WIDTH  column of the newest pixel p[0][0]
row  out  ADDR_WIDTH  row of the newest pixel p[0][0]
eof  out  1  one-cycle pulse: last pixel of frame accepted

Behaviour:
- Reset (async on reset_n low): all taps 0, line-buffer pointers 0, col=row=0, dout_valid=0, eof=0. Line-buffer RAM contents are undefined and are not cleared. The first accepted pixel after reset is treated as (0,0), whether or not sof is asserted.
- On an accepted cycle (en=1), with n as the stream index of the accepted pixel: after the edge, p[i][j] = pixel n - i*FRAME_WIDTH - j. Latency from din to p[0][0] is 1 clk.
- Shift structure: p[i][j] <= p[i][j-1]; p[0][0] <= din; p[i][0] <= line-buffer i output. Line buffer i is fed from p[i-1][WIN_W-1].
- en=0: taps, counters, pointers and outputs hold. dout_valid and eof drop to 0.
- Position counters describe the pixel in p[0][0] and update on the same edge as the taps.
  - col increments and wraps at FRAME_WIDTH-1 to 0; row increments on that wrap.
  - row wraps at FRAME_HEIGHT-1 to 0, so back-to-back frames run without sof.
- sof with en: col<=0, row<=0 for that pixel. This applies mid-frame too, which aborts the current frame; taps and line buffers are not flushed. sof without en is ignored.
- dout_valid <= en && (new row >= WIN_H-1) && (new col >= WIN_W-1). Registered alongside the taps. Windows that would straddle a row or frame boundary are never flagged.
- eof <= en && new col==FRAME_WIDTH-1 && new row==FRAME_HEIGHT-1. If sof coincides, sof wins: eof=0 and position is (0,0).
- WIN_H=1: no line buffers. WIN_W=1: the line buffer feeds p[i][0] directly from p[i-1][0].

Decomposition:
- global.vh holds WORD_SIZE, FRAME_WIDTH and FRAME_HEIGHT defaults.
- One sub-module, line_buffer (params WORD_SIZE, DEPTH=FRAME_WIDTH-WIN_W, ADDR_WIDTH):
  - circular RAM with a single pointer;
  - combinational read of mem[ptr], which is the value written DEPTH accepts ago;
  - on en, writes din at ptr and advances the pointer, wrapping DEPTH-1 to 0;
  - pointer resets asynchronously to 0.
- One instance per row 1..WIN_H-1 via generate.

Test Plan:
(Params FRAME_WIDTH=8, FRAME_HEIGHT=6, WIN_W=WIN_H=3, WORD_SIZE=8; din = raster index; sof on pixel 0.)
1. Stream 48 pixels with en=1 -> first dout_valid after pixel 18 (row2,col2) with p[0][0]=18, p[0][2]=16, p[1][1]=9, p[2][2]=0; exactly 24 valid pulses; eof once, after pixel 47.
2. Same stream with en toggled pseudo-randomly -> identical window sequence and valid count; all outputs hold during en=0, and dout_valid/eof are 0 then.
3. Two back-to-back frames without a second sof -> second frame starts at (0,0); 24 valids per frame; p taps continue across the boundary.
4. sof asserted with pixel 20 mid-frame -> col=row=0 after the edge; no dout_valid until 18 further pixels accepted.
5. reset_n pulsed low asynchronously mid-row (between edges) -> outputs 0 immediately; the next accepted pixel is reported as (0,0), first valid 18 pixels later.
6. sof without en at pixel 10 -> ignored; counters continue (next accepted pixel is col 3, row 1).
